joypad_matrix_io: RTL and testbench
===================================

// Module: joypad_matrix_io
// PURPOSE
//  Parametrised successor to the DMG joypad port: NSEL active-low select lines drive a key matrix,
//  NIN active-low return lines are synchronised, optionally debounced and read back over the CPU bus.
//  Adds joypad interrupt request (falling edge on any selected return line), a post-select settle
//  window and a STOP-mode wake level. Sits on the FF00-style register slot beside the serial/IO glue.
// PARAMETERS
//  NSEL      2   number of select (column) outputs; NSEL+NIN <= 8
//  NIN       4   number of return (row) inputs, active-low, 0 = pressed
//  SYNC      2   synchroniser stages on p_in (>=2)
//  DB_CYCLES 16  cycles an input must be stable before the debounced copy follows it (>=2)
//  SETTLE    4   cycles after a select change during which IRQ/debounce are frozen (>=1)
// PORTS
//  clk       in   1         system clock, all state on rising edge
//  nreset    in   1         asynchronous active-low reset
//  wr        in   1         register write strobe (one cycle)
//  rd        in   1         register read enable
//  din       in   8         write data; select bits at din[NIN+NSEL-1:NIN]
//  dout      out  8         read data
//  p_sel_n   out  NSEL      select drive, active-low
//  p_in      in   NIN       raw return lines, asynchronous
//  irq       out  1         joypad interrupt flag (sticky)
//  irq_ack   in   1         clears irq
//  wake      out  1         level: any selected key pressed
// BEHAVIOUR
//  Reset: sel_q=all 1; sync stages=all 1; stable=all 1; counters=0; state=IDLE; irq=0; wake=0;
//    p_sel_n=all 1; dout=8'hFF.
//  Write: wr -> sel_q <= din[NIN+NSEL-1:NIN] next edge; p_sel_n = sel_q (registered, 1 cycle).
//  Sync: p_in through SYNC flops; sync value = last stage. view = stable (debounce) or sync.
//  Read: dout = rd ? {1s above NIN+NSEL, sel_q, view} : 8'hFF; combinational from registered state.
//  FSM IDLE/SETTLE: wr with din select != sel_q -> SETTLE, settle counter loaded SETTLE-1.
//    Write of identical value stays IDLE. In SETTLE: counter decrements; debounce counters held 0,
//    stable <= sync every cycle, no IRQ edges. Counter==0 -> IDLE. New select change in SETTLE
//    reloads counter (restart window).
//  Debounce (IDLE, per bit): sync!=stable -> cnt++; cnt==DB_CYCLES-1 with mismatch -> stable<=sync,
//    cnt<=0. sync==stable -> cnt<=0. Glitch shorter than DB_CYCLES never reaches stable.
//  IRQ: edge = previous view bit 1 and current view bit 0, any bit, in IDLE, and |~sel_q.
//    edge -> irq<=1. irq_ack -> irq<=0. edge and irq_ack same cycle -> irq=1 (set wins).
//    All selects high: no edges, wake=0.
//  wake = (|~sel_q) & (|~view), registered one cycle.
//  Reset mid-debounce/settle: all state returns to reset values immediately; no spurious irq after
//    release since view and its previous copy both reset to 1s.
// CONFIGURATION
//  JOYPAD_DEBOUNCE_EN defined: debounce counters present, view = stable.
//  Undefined: no counters; stable tracks sync each cycle; view = sync; DB_CYCLES ignored;
//    SETTLE freeze and IRQ rules unchanged.
// TESTING
//  1 Reset, rd=1 -> dout=8'hFF, irq=0, p_sel_n=2'b11, wake=0.
//  2 wr din=8'h20 (sel=2'b10), wait SETTLE+SYNC+2, p_in=4'b1110 held -> with debounce, dout[3:0]
//    =4'hE exactly DB_CYCLES cycles after sync sees it; irq=1 one cycle later; wake=1.
//  3 Debounce on: 5-cycle low pulse on p_in[2] -> dout[3:0] stays 4'hF, irq stays 0.
//  4 p_in[0] held low, wr sel 2'b10 -> 2'b01 -> no irq during SETTLE; after SETTLE,
//    view shows bit0=0, irq stays 0.
//  5 Pending edge coincides with irq_ack=1 -> irq=1 after that edge; next irq_ack alone -> irq=0.
//  6 nreset low for 1 cycle mid-count (cnt=8) -> outputs at reset values; release with
//    p_in=4'hF -> no irq within 2*DB_CYCLES.

Source files
------------

// File: rtl/joypad_matrix_io_if.sv
// ----------------------------------------------------------------------------
// joypad_matrix_io_if
//   CPU-side register bus for the joypad matrix port.
//   master : CPU / bus fabric (drives wr, rd, din, irq_ack)
//   slave  : joypad_matrix_io (drives dout, irq, wake)
//   Signals:
//     wr       register write strobe (one cycle)
//     rd       register read enable
//     din[7:0] write data, select bits sit directly above the return bits
//     dout[7:0] read data, 8'hFF when rd is low
//     irq      sticky joypad interrupt flag
//     irq_ack  clears irq
//     wake     level, any selected key pressed
// ----------------------------------------------------------------------------
interface joypad_matrix_io_if;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic       irq_ack;
    logic       wake;

    modport master (
        output wr, rd, din, irq_ack,
        input  dout, irq, wake
    );

    modport slave (
        input  wr, rd, din, irq_ack,
        output dout, irq, wake
    );
endinterface

// File: rtl/joypad_matrix_io.sv
// ----------------------------------------------------------------------------
// joypad_matrix_io
//   Joypad matrix port: NSEL active-low select lines drive the key matrix,
//   NIN active-low return lines are synchronised, optionally debounced and
//   read back over the CPU register bus. Raises a sticky interrupt on a
//   falling edge of any return line while at least one select is active,
//   freezes edge detection for SETTLE cycles after a select change, and
//   provides a STOP-mode wake level.
//
//   Optional feature: define JOYPAD_DEBOUNCE_EN to add per-bit debounce
//   counters (view = debounced copy). Without it the view is the raw
//   synchronised value.
//
//   Ports:
//     clk      system clock, all state on rising edge
//     nreset   asynchronous active-low reset
//     bus      joypad_matrix_io_if.slave (wr, rd, din, dout, irq, irq_ack, wake)
//     p_sel_n  select drive, active-low, registered copy of the select register
//     p_in     raw asynchronous return lines, 0 = pressed
// ----------------------------------------------------------------------------
module joypad_matrix_io #(
    parameter int NSEL      = 2,
    parameter int NIN       = 4,
    parameter int SYNC      = 2,
    parameter int DB_CYCLES = 16,
    parameter int SETTLE    = 4
) (
    input  logic              clk,
    input  logic              nreset,
    joypad_matrix_io_if.slave bus,
    output logic [NSEL-1:0]   p_sel_n,
    input  logic [NIN-1:0]    p_in
);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [SCW-1:0]           settle_cnt_reg, settle_cnt_next;
    logic [NSEL-1:0]          sel_reg;
    logic [NSEL-1:0]          p_sel_n_reg;
    logic [SYNC-1:0][NIN-1:0] sync_reg;
    logic [NIN-1:0]           view_prev_reg;
    logic                     irq_reg;
    logic                     wake_reg;

    logic [NSEL-1:0]          din_sel;
    logic [NIN-1:0]           sync_val;
    logic [NIN-1:0]           view;
    logic                     sel_change;
    logic                     frozen;
    logic                     sel_active;
    logic                     edge_hit;
    logic [7:0]               rd_word;

    assign din_sel    = bus.din[NIN+NSEL-1:NIN];
    assign sel_change = bus.wr && (din_sel != sel_reg);
    assign frozen     = (state_reg == ST_SETTLE);
    assign sel_active = |(~sel_reg);
    assign sync_val   = sync_reg[SYNC-1];

    // ------------------------------------------------------------------
    // Settle FSM: any select change (even inside the window) restarts it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        if (sel_change) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = SETTLE_LOAD;
        end else if (state_reg == ST_SETTLE) begin
            if (settle_cnt_reg == '0) begin
                state_next = ST_IDLE;
            end else begin
                settle_cnt_next = settle_cnt_reg - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 samples the pins, last stage is used.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC-2:0], p_in};
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [NIN-1:0] stable_vec;

    // Each return bit follows its synchronised value only after it has
    // disagreed for DB_CYCLES consecutive cycles. While settling after a
    // select change the debounced copy is forced to the synchronised value
    // so stale column data never has to age out.
    for (genvar gi = 0; gi < NIN; gi++) begin : g_db
        logic [DBW-1:0] cnt_reg;
        logic           stable_reg;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                cnt_reg    <= '0;
                stable_reg <= 1'b1;
            end else if (frozen) begin
                cnt_reg    <= '0;
                stable_reg <= sync_val[gi];
            end else if (sync_val[gi] == stable_reg) begin
                cnt_reg    <= '0;
            end else if (cnt_reg == DB_LAST) begin
                cnt_reg    <= '0;
                stable_reg <= sync_val[gi];
            end else begin
                cnt_reg    <= cnt_reg + 1'b1;
            end
        end

        assign stable_vec[gi] = stable_reg;
    end

    assign view = stable_vec;
`else
    assign view = sync_val;
`endif

    // Falling edge on any return bit, only outside the settle window and
    // only while some column is actually selected.
    assign edge_hit = !frozen && sel_active && (|(view_prev_reg & ~view));

    // ------------------------------------------------------------------
    // Select register, pin drive, interrupt and wake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sel_reg       <= '1;
            p_sel_n_reg   <= '1;
            view_prev_reg <= '1;
            irq_reg       <= 1'b0;
            wake_reg      <= 1'b0;
        end else begin
            if (bus.wr) begin
                sel_reg <= din_sel;
            end
            p_sel_n_reg   <= sel_reg;
            view_prev_reg <= view;
            // A new edge wins over a simultaneous acknowledge.
            if (edge_hit) begin
                irq_reg <= 1'b1;
            end else if (bus.irq_ack) begin
                irq_reg <= 1'b0;
            end
            wake_reg <= sel_active & (|(~view));
        end
    end

    // Read word: unused upper bits read as 1.
    always_comb begin
        rd_word                  = '1;
        rd_word[NIN-1:0]         = view;
        rd_word[NIN+NSEL-1:NIN]  = sel_reg;
    end

    assign bus.dout = bus.rd ? rd_word : 8'hFF;
    assign bus.irq  = irq_reg;
    assign bus.wake = wake_reg;
    assign p_sel_n  = p_sel_n_reg;

endmodule

// File: tb/tb_joypad_matrix_io.sv
// ----------------------------------------------------------------------------
// tb_joypad_matrix_io
//   Scenario tasks plus a randomized run, each cycle compared against a
//   behavioural model that tracks "age since last select change" and
//   per-bit "cycles of disagreement" rather than the RTL's counters.
// ----------------------------------------------------------------------------
module tb_joypad_matrix_io;
    localparam int NSEL   = 2;
    localparam int NIN    = 4;
    localparam int SYNC   = 2;
    localparam int DB     = 16;
    localparam int SETTLE = 4;
`ifdef JOYPAD_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic            clk;
    logic            nreset;
    logic [NSEL-1:0] p_sel_n;
    logic [NIN-1:0]  p_in_tb;

    joypad_matrix_io_if bus ();

    joypad_matrix_io #(
        .NSEL(NSEL), .NIN(NIN), .SYNC(SYNC), .DB_CYCLES(DB), .SETTLE(SETTLE)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave),
        .p_sel_n(p_sel_n),
        .p_in   (p_in_tb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    logic [NSEL-1:0] m_sel;
    logic [NIN-1:0]  m_hist [SYNC];   // m_hist[0] = newest sampled pins
    logic [NIN-1:0]  m_stable;
    int              m_run [NIN];     // consecutive cycles sync disagreed with stable
    logic [NIN-1:0]  m_prev;
    logic            m_irq;
    logic            m_wake;
    logic [NSEL-1:0] m_psel;
    int              m_since;         // clock edges since the last select change

    function automatic logic [NIN-1:0] model_view();
        if (DB_ON) return m_stable;
        return m_hist[SYNC-1];
    endfunction

    function automatic bit model_edge();
        logic [NIN-1:0] v;
        v = model_view();
        return (m_since >= SETTLE) && (m_sel != '1) && ((m_prev & ~v) != '0);
    endfunction

    task automatic model_reset();
        m_sel = '1; m_stable = '1; m_prev = '1; m_irq = 1'b0; m_wake = 1'b0;
        m_psel = '1; m_since = 1000;
        for (int i = 0; i < SYNC; i++) m_hist[i] = '1;
        for (int b = 0; b < NIN; b++) m_run[b] = 0;
    endtask

    task automatic model_step();
        logic [NIN-1:0]  s, v;
        logic [NSEL-1:0] nsel;
        bit              frz, ed;
        if (!nreset) begin
            model_reset();
            return;
        end
        s    = m_hist[SYNC-1];
        v    = model_view();
        frz  = (m_since < SETTLE);
        ed   = model_edge();
        nsel = bus.din[NIN+NSEL-1:NIN];
        if (ed) m_irq = 1'b1;
        else if (bus.irq_ack) m_irq = 1'b0;
        m_wake = (m_sel != '1) && (v != '1);
        m_prev = v;
        m_psel = m_sel;
        for (int b = 0; b < NIN; b++) begin
            if (frz || !DB_ON) begin
                m_stable[b] = s[b];
                m_run[b]    = 0;
            end else if (s[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_stable[b] = s[b];
                    m_run[b]    = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        if (bus.wr && nsel != m_sel) m_since = 0;
        else if (m_since < 1000) m_since++;
        if (bus.wr) m_sel = nsel;
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = p_in_tb;
    endtask

    function automatic logic [11:0] exp_vec();
        logic [7:0] d;
        d = bus.rd ? {2'b11, m_sel, model_view()} : 8'hFF;
        return {d, m_irq, m_psel, m_wake};
    endfunction

    function automatic logic [11:0] got_vec();
        return {bus.dout, bus.irq, p_sel_n, bus.wake};
    endfunction

    // Advance one clock: model consumes the inputs the DUT will sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nreset = 1'b0; model_reset();
        bus.wr = 1'b0; bus.rd = 1'b1; bus.din = 8'h00; bus.irq_ack = 1'b0; p_in_tb = '1;
        repeat (3) tick();
        n_checks++;
        if (bus.dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout got=%h exp=ff", bus.dout); end
        n_checks++;
        if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
        n_checks++;
        if (p_sel_n !== 2'b11) begin n_fail++; $display("FAIL reset_psel got=%b exp=11", p_sel_n); end
        n_checks++;
        if (bus.wake !== 1'b0) begin n_fail++; $display("FAIL reset_wake got=%b exp=0", bus.wake); end
        nreset = 1'b1;
        tick();
        n_checks++;
        if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", got_vec(), exp_vec()); end
        $display("test_reset done checks=%0d", n_checks);
    endtask

    task automatic test_press();
        int lat, irq_k;
        lat = -1; irq_k = -1;
        bus.wr = 1'b1; bus.din = 8'h20;
        tick();
        bus.wr = 1'b0;
        for (int i = 0; i < SETTLE + SYNC + 2; i++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL press_settle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec()); end
        end
        p_in_tb = 4'b1110;
        for (int k = 1; k <= 60; k++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL press_model cyc=%0d got=%h exp=%h", k, got_vec(), exp_vec()); end
            if (lat < 0 && bus.dout[3:0] == 4'hE) lat = k;
            if (irq_k < 0 && bus.irq == 1'b1) irq_k = k;
        end
        n_checks++;
        if (lat != SYNC + (DB_ON ? DB : 0)) begin n_fail++; $display("FAIL press_latency got=%0d exp=%0d", lat, SYNC + (DB_ON ? DB : 0)); end
        n_checks++;
        if (irq_k != SYNC + (DB_ON ? DB : 0) + 1) begin n_fail++; $display("FAIL press_irq_time got=%0d exp=%0d", irq_k, SYNC + (DB_ON ? DB : 0) + 1); end
        n_checks++;
        if ({bus.dout[3:0], bus.irq, bus.wake} !== 6'b1110_1_1) begin
            n_fail++; $display("FAIL press_final got=%b exp=111011", {bus.dout[3:0], bus.irq, bus.wake});
        end
        $display("test_press done latency=%0d irq_at=%0d", lat, irq_k);
    endtask

    task automatic test_glitch();
        bit irq_seen;
        p_in_tb = '1;
        for (int i = 0; i < 2 * DB + SYNC; i++) tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        irq_seen = 1'b0;
        p_in_tb = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL glitch_low cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec()); end
            irq_seen |= bus.irq;
        end
        p_in_tb = '1;
        for (int i = 0; i < 2 * DB; i++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL glitch_high cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec()); end
            irq_seen |= bus.irq;
        end
        n_checks++;
        if (irq_seen !== !DB_ON) begin n_fail++; $display("FAIL glitch_irq got=%b exp=%b", irq_seen, !DB_ON); end
        $display("test_glitch done irq_seen=%b", irq_seen);
    endtask

    task automatic test_settle();
        bit irq_seen;
        p_in_tb = 4'b1110;
        for (int i = 0; i < DB + SYNC + 4; i++) tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        irq_seen = 1'b0;
        bus.wr = 1'b1; bus.din = 8'h10;
        tick();
        bus.wr = 1'b0;
        for (int i = 0; i < SETTLE + 2 * DB; i++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL settle_model cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec()); end
            irq_seen |= bus.irq;
        end
        n_checks++;
        if ({irq_seen, bus.dout[5:4], bus.dout[0]} !== 4'b0010) begin
            n_fail++; $display("FAIL settle_final got=%b exp=0010", {irq_seen, bus.dout[5:4], bus.dout[0]});
        end
        $display("test_settle done irq_seen=%b", irq_seen);
    endtask

    task automatic test_ack_collision();
        bit found;
        p_in_tb = '1;
        for (int i = 0; i < DB + SYNC + 4; i++) tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        p_in_tb = 4'b1011;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (model_edge()) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL collide_wait got=no_edge exp=edge_within_100");
        end else begin
            bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
            n_checks++;
            if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL collide_set got=%b exp=1", bus.irq); end
            tick();
            bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
            n_checks++;
            if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL collide_clear got=%b exp=0", bus.irq); end
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL collide_model got=%h exp=%h", got_vec(), exp_vec()); end
        end
        $display("test_ack_collision done found=%b", found);
    endtask

    task automatic test_reset_mid();
        bit irq_seen;
        p_in_tb = '1;
        for (int i = 0; i < DB + SYNC + 4; i++) tick();
        p_in_tb = 4'b0111;
        for (int i = 0; i < SYNC + 8; i++) tick();
        nreset = 1'b0; model_reset();
        #1;
        n_checks++;
        if (got_vec() !== {8'hFF, 1'b0, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL midreset_outputs got=%h exp=%h", got_vec(), {8'hFF, 1'b0, 2'b11, 1'b0});
        end
        @(negedge clk);
        tick();
        p_in_tb = '1;
        nreset = 1'b1;
        irq_seen = 1'b0;
        for (int i = 0; i < 2 * DB; i++) begin
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL midreset_model cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec()); end
            irq_seen |= bus.irq;
        end
        n_checks++;
        if (irq_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_irq got=%b exp=0", irq_seen); end
        $display("test_reset_mid done irq_seen=%b", irq_seen);
    endtask

    task automatic test_random();
        int r, errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.wr      = ($urandom_range(0, 11) == 0);
            bus.din     = 8'($urandom());
            bus.rd      = ($urandom_range(0, 3) != 0);
            bus.irq_ack = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 24);
            if (r == 0) p_in_tb = 4'($urandom());
            else if (r == 1) p_in_tb[$urandom_range(0, NIN - 1)] ^= 1'b1;
            tick();
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; errs++;
                if (errs <= 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        bus.wr = 1'b0; bus.irq_ack = 1'b0; bus.rd = 1'b1;
        $display("test_random done cycles=1500 errors=%0d", errs);
    endtask

    initial begin
        nreset = 1'b0;
        test_reset();
        test_press();
        test_glitch();
        test_settle();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
